// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: trap CSRs, 64-bit cycle/instret counters,
// interrupt-pending generation and the mtvec/mepc taps for the pipe control.
module csr_regfile #(
   parameter logic [31:0] HART_ID    = 32'h0,
   parameter logic [31:0] MISA_VAL   = 32'h4000_1100,
   parameter bit          COUNTER_EN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [11:0] raddr_i,
   output logic [31:0] rdata_o,
   output logic        illegal_o,
   input  logic        we_i,
   input  logic [11:0] waddr_i,
   input  logic [31:0] wdata_i,
   input  logic        instret_i,
   input  logic        trap_i,
   input  logic [31:0] trap_cause_i,
   input  logic [31:0] trap_pc_i,
   input  logic [31:0] trap_val_i,
   input  logic        mret_i,
   input  logic        ext_irq_i,
   input  logic        tmr_irq_i,
   output logic        irq_pending_o,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   // architectural state
   logic        st_mie;
   logic        st_mpie;
   logic        mie_msie;
   logic        mie_mtie;
   logic        mie_meie;
   logic [31:2] mtvec_q;
   logic [31:0] mscratch_q;
   logic [31:2] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] mtval_q;
   logic [63:0] mcycle_q;
   logic [63:0] minstret_q;
   logic        irq_q;

   // decoded write strobes
   logic wr_mstatus;
   logic wr_mie;
   logic wr_mtvec;
   logic wr_mscratch;
   logic wr_mepc;
   logic wr_mcause;
   logic wr_mtval;
   logic wr_mcycle;
   logic wr_mcycleh;
   logic wr_minstret;
   logic wr_minstreth;

   logic        trap_busy;
   logic [31:0] mstatus_rd;
   logic [31:0] mie_rd;
   logic [31:0] mip_rd;
   logic        unused_pc_bits;

   assign unused_pc_bits = ^trap_pc_i[1:0];

   // trap/mret own mstatus, mepc, mcause and mtval in their cycle
   assign trap_busy = trap_i | mret_i;

   assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
   assign mie_rd     = {20'b0, mie_meie, 3'b0, mie_mtie, 3'b0, mie_msie, 3'b0};
   assign mip_rd     = {20'b0, ext_irq_i, 3'b0, tmr_irq_i, 7'b0};

   assign mtvec_o       = {mtvec_q, 2'b00};
   assign mepc_o        = {mepc_q, 2'b00};
   assign irq_pending_o = irq_q;

   // Write address decode; read-only and unknown addresses produce no strobe
   always_comb begin
      wr_mstatus   = 1'b0;
      wr_mie       = 1'b0;
      wr_mtvec     = 1'b0;
      wr_mscratch  = 1'b0;
      wr_mepc      = 1'b0;
      wr_mcause    = 1'b0;
      wr_mtval     = 1'b0;
      wr_mcycle    = 1'b0;
      wr_mcycleh   = 1'b0;
      wr_minstret  = 1'b0;
      wr_minstreth = 1'b0;
      if (we_i) begin
         case (waddr_i)
            A_MSTATUS:   wr_mstatus   = ~trap_busy;
            A_MIE:       wr_mie       = 1'b1;
            A_MTVEC:     wr_mtvec     = 1'b1;
            A_MSCRATCH:  wr_mscratch  = 1'b1;
            A_MEPC:      wr_mepc      = ~trap_busy;
            A_MCAUSE:    wr_mcause    = ~trap_busy;
            A_MTVAL:     wr_mtval     = ~trap_busy;
            A_MCYCLE:    wr_mcycle    = COUNTER_EN;
            A_MCYCLEH:   wr_mcycleh   = COUNTER_EN;
            A_MINSTRET:  wr_minstret  = COUNTER_EN;
            A_MINSTRETH: wr_minstreth = COUNTER_EN;
            default: ;
         endcase
      end
   end

   // Combinational read mux, no bypass of the pending write
   always_comb begin
      rdata_o   = '0;
      illegal_o = 1'b0;
      case (raddr_i)
         A_MSTATUS:               rdata_o = mstatus_rd;
         A_MISA:                  rdata_o = MISA_VAL;
         A_MIE:                   rdata_o = mie_rd;
         A_MTVEC:                 rdata_o = {mtvec_q, 2'b00};
         A_MSCRATCH:              rdata_o = mscratch_q;
         A_MEPC:                  rdata_o = {mepc_q, 2'b00};
         A_MCAUSE:                rdata_o = mcause_q;
         A_MTVAL:                 rdata_o = mtval_q;
         A_MIP:                   rdata_o = mip_rd;
         A_MCYCLE,   A_CYCLE:     rdata_o = mcycle_q[31:0];
         A_MCYCLEH,  A_CYCLEH:    rdata_o = mcycle_q[63:32];
         A_MINSTRET, A_INSTRET:   rdata_o = minstret_q[31:0];
         A_MINSTRETH, A_INSTRETH: rdata_o = minstret_q[63:32];
         A_MHARTID:               rdata_o = HART_ID;
         default:                 illegal_o = 1'b1;
      endcase
   end

   // mstatus: trap stacks MIE into MPIE, mret restores it, else software write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_mie  <= 1'b0;
         st_mpie <= 1'b0;
      end else if (trap_i) begin
         st_mpie <= st_mie;
         st_mie  <= 1'b0;
      end else if (mret_i) begin
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
      end else if (wr_mstatus) begin
         st_mie  <= wdata_i[3];
         st_mpie <= wdata_i[7];
      end
   end

   // Trap capture registers; trap entry overrides any software write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mepc_q   <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
      end else if (trap_i) begin
         mepc_q   <= trap_pc_i[31:2];
         mcause_q <= trap_cause_i;
         mtval_q  <= trap_val_i;
      end else begin
         if (wr_mepc)   mepc_q   <= wdata_i[31:2];
         if (wr_mcause) mcause_q <= wdata_i;
         if (wr_mtval)  mtval_q  <= wdata_i;
      end
   end

   // Plain software-written CSRs, unaffected by trap or mret
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mie_msie   <= 1'b0;
         mie_mtie   <= 1'b0;
         mie_meie   <= 1'b0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
      end else begin
         if (wr_mie) begin
            mie_msie <= wdata_i[3];
            mie_mtie <= wdata_i[7];
            mie_meie <= wdata_i[11];
         end
         if (wr_mtvec)    mtvec_q    <= wdata_i[31:2];
         if (wr_mscratch) mscratch_q <= wdata_i;
      end
   end

   // Cycle counter: a write to one half wins and freezes the other half
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcycle_q <= '0;
      end else if (COUNTER_EN) begin
         if (wr_mcycle)       mcycle_q[31:0]  <= wdata_i;
         else if (wr_mcycleh) mcycle_q[63:32] <= wdata_i;
         else                 mcycle_q        <= mcycle_q + 64'd1;
      end
   end

   // Retired-instruction counter, same write-wins rule as the cycle counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         minstret_q <= '0;
      end else if (COUNTER_EN) begin
         if (wr_minstret)       minstret_q[31:0]  <= wdata_i;
         else if (wr_minstreth) minstret_q[63:32] <= wdata_i;
         else if (instret_i)    minstret_q        <= minstret_q + 64'd1;
      end
   end

   // Registered interrupt request from enabled, pending sources
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) irq_q <= 1'b0;
      else         irq_q <= st_mie & |(mie_rd & mip_rd);
   end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed-vector bench for csr_regfile with hand-computed expectations.
module tb_csr_regfile;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [11:0] raddr_i = '0;
   logic [31:0] rdata_o;
   logic        illegal_o;
   logic        we_i = 1'b0;
   logic [11:0] waddr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        instret_i = 1'b0;
   logic        trap_i = 1'b0;
   logic [31:0] trap_cause_i = '0;
   logic [31:0] trap_pc_i = '0;
   logic [31:0] trap_val_i = '0;
   logic        mret_i = 1'b0;
   logic        ext_irq_i = 1'b0;
   logic        tmr_irq_i = 1'b0;
   logic        irq_pending_o;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   csr_regfile #(.HART_ID(32'h0), .MISA_VAL(32'h4000_1100), .COUNTER_EN(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .raddr_i(raddr_i), .rdata_o(rdata_o),
      .illegal_o(illegal_o), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .instret_i(instret_i), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
      .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i), .mret_i(mret_i),
      .ext_irq_i(ext_irq_i), .tmr_irq_i(tmr_irq_i), .irq_pending_o(irq_pending_o),
      .mtvec_o(mtvec_o), .mepc_o(mepc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      raddr_i = a;
      #1;
      check(tag, rdata_o, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      we_i = 1'b1;
      waddr_i = a;
      wdata_i = d;
      tick();
      we_i = 1'b0;
   endtask

   initial begin
      // 1. reset values
      #2;
      check("rst_irq", {31'b0, irq_pending_o}, 32'h0);
      check("rst_mepc_o", mepc_o, 32'h0);
      #10 rst_ni = 1'b1;
      repeat (10) tick();
      rd("mhartid", 12'hF14, 32'h0);
      rd("misa", 12'h301, 32'h4000_1100);
      rd("mstatus_rst", 12'h300, 32'h0000_1800);
      check("legal_300", {31'b0, illegal_o}, 32'h0);
      rd("unimpl_rd", 12'h7C0, 32'h0);
      check("unimpl_ill", {31'b0, illegal_o}, 32'h1);

      // 2. write masks
      wr(12'h305, 32'hFFFF_FFFF);
      wr(12'h341, 32'hFFFF_FFFF);
      wr(12'h304, 32'hFFFF_FFFF);
      wr(12'h301, 32'hFFFF_FFFF);
      rd("mtvec_mask", 12'h305, 32'hFFFF_FFFC);
      rd("mepc_mask", 12'h341, 32'hFFFF_FFFC);
      rd("mie_mask", 12'h304, 32'h0000_0888);
      rd("misa_ro", 12'h301, 32'h4000_1100);
      check("mtvec_o", mtvec_o, 32'hFFFF_FFFC);
      wr(12'h340, 32'hA5A5_0003);
      rd("mscratch", 12'h340, 32'hA5A5_0003);
      // no write bypass: value visible only after the edge
      we_i = 1'b1; waddr_i = 12'h340; wdata_i = 32'h1234_5678;
      rd("no_bypass", 12'h340, 32'hA5A5_0003);
      tick();
      we_i = 1'b0;
      rd("mscratch2", 12'h340, 32'h1234_5678);
      wr(12'h304, 32'h0);

      // 3. counter carry, write priority, wrap
      wr(12'hB80, 32'h5);
      wr(12'hB00, 32'hFFFF_FFFE);
      rd("mcycle_wr", 12'hB00, 32'hFFFF_FFFE);
      rd("mcycleh_hold", 12'hB80, 32'h5);
      tick();
      rd("mcycle_m1", 12'hB00, 32'hFFFF_FFFF);
      rd("mcycleh_m1", 12'hB80, 32'h5);
      tick();
      rd("mcycle_carry", 12'hB00, 32'h0);
      rd("mcycleh_carry", 12'hC80, 32'h6);
      wr(12'hB80, 32'hFFFF_FFFF);
      wr(12'hB00, 32'hFFFF_FFFF);
      rd("wrap_lo_pre", 12'hC00, 32'hFFFF_FFFF);
      rd("wrap_hi_pre", 12'hB80, 32'hFFFF_FFFF);
      tick();
      rd("wrap_lo", 12'hB00, 32'h0);
      rd("wrap_hi", 12'hB80, 32'h0);
      for (int i = 0; i < 3; i++) begin
         instret_i = 1'b1;
         tick();
         instret_i = 1'b0;
         tick();
      end
      rd("instret3", 12'hC02, 32'h3);
      rd("instreth", 12'hC82, 32'h0);
      instret_i = 1'b1;
      wr(12'hB02, 32'd10);
      instret_i = 1'b0;
      rd("minstret_wr_wins", 12'hB02, 32'd10);
      wr(12'hC02, 32'h77);
      rd("instret_ro", 12'hB02, 32'd10);

      // 4. trap and mret
      wr(12'h300, 32'h8);
      rd("mstatus_mie", 12'h300, 32'h0000_1808);
      trap_i = 1'b1; trap_pc_i = 32'h1002; trap_cause_i = 32'h8000_000B; trap_val_i = 32'h55;
      tick();
      trap_i = 1'b0;
      check("trap_mepc_o", mepc_o, 32'h1000);
      rd("trap_mcause", 12'h342, 32'h8000_000B);
      rd("trap_mtval", 12'h343, 32'h55);
      rd("trap_mstatus", 12'h300, 32'h0000_1880);
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h0000_1888);

      // 5. interrupt
      wr(12'h304, 32'h800);
      ext_irq_i = 1'b1;
      rd("mip_ext", 12'h344, 32'h0000_0800);
      check("irq_late", {31'b0, irq_pending_o}, 32'h0);
      tick();
      check("irq_set", {31'b0, irq_pending_o}, 32'h1);
      tmr_irq_i = 1'b1;
      rd("mip_both", 12'h344, 32'h0000_0880);
      tmr_irq_i = 1'b0;
      wr(12'h300, 32'h0);
      check("irq_hold", {31'b0, irq_pending_o}, 32'h1);
      tick();
      check("irq_clr", {31'b0, irq_pending_o}, 32'h0);
      ext_irq_i = 1'b0;

      // 6. async reset between edges, then same-cycle trap/mret vs write
      tick();
      #2 rst_ni = 1'b0;
      #1;
      rd("arst_mcycle", 12'hB00, 32'h0);
      rd("arst_mstatus", 12'h300, 32'h0000_1800);
      check("arst_mtvec_o", mtvec_o, 32'h0);
      #2 rst_ni = 1'b1;
      tick();
      trap_i = 1'b1; trap_pc_i = 32'h3006; trap_cause_i = 32'h2; trap_val_i = 32'h9;
      wr(12'h341, 32'h2000);
      trap_i = 1'b0;
      check("trap_beats_wr", mepc_o, 32'h3004);
      rd("trap_cause2", 12'h342, 32'h2);
      trap_i = 1'b1; trap_pc_i = 32'h4000;
      wr(12'h340, 32'hCAFE_0001);
      trap_i = 1'b0;
      rd("trap_other_wr", 12'h340, 32'hCAFE_0001);
      mret_i = 1'b1;
      wr(12'h300, 32'h8);
      mret_i = 1'b0;
      rd("mret_beats_wr", 12'h300, 32'h0000_1880);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
Machine-mode CSR register file. It is the responder for the execute stage's CSR read port (raddr/rdata) and the sink for the CSR write stream that execute forwards through exe_mem.
Holds the RV32 machine trap CSRs, the 64-bit cycle/instret counters and interrupt-pending logic. It also exposes mtvec/mepc to pipe_ctrl for trap entry and mret.
Sits beside regs in the core, outside the pipeline registers.

Parameters:
HART_ID, 32'h0, value returned by mhartid (0xF14)
MISA_VAL, 32'h40001100, read-only misa value (RV32IM)
COUNTER_EN, 1, 0 = counters held at 0 and never increment

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
raddr_i  in  12  CSR read address from exe
rdata_o  out  32  CSR read data to exe, combinational
illegal_o  out  1  raddr_i not implemented, combinational
we_i  in  1  CSR write enable from exe_mem
waddr_i  in  12  CSR write address
wdata_i  in  32  CSR write data, final value after CSRRW/S/C computed upstream
instret_i  in  1  one pulse per retired instruction
trap_i  in  1  trap entry, one-cycle pulse
trap_cause_i  in  32  mcause value for trap
trap_pc_i  in  32  faulting/interrupted PC
trap_val_i  in  32  mtval value
mret_i  in  1  mret executed, one-cycle pulse
ext_irq_i  in  1  machine external interrupt, level
tmr_irq_i  in  1  machine timer interrupt, level
irq_pending_o  out  1  enabled interrupt pending, registered
mtvec_o  out  32  current mtvec
mepc_o  out  32  current mepc

Behaviour:
Reset is asynchronous (rst_ni low):
- all CSRs are 0, except mstatus.MPP, which reads 2'b11.
- irq_pending_o is 0.
- rdata_o and illegal_o follow the reset register contents.

Implemented CSRs and write masks. All other bits are read-only 0.
- mstatus 0x300: MIE bit3, MPIE bit7 writable; MPP bits12:11 always 2'b11.
- misa 0x301 and mhartid 0xF14: read-only parameter values.
- mie 0x304: bits 3, 7, 11 writable.
- mtvec 0x305: bits 31:2 writable; bits 1:0 read 0 (direct mode only).
- mscratch 0x340: all 32 bits writable.
- mepc 0x341: bits 31:2 writable; bits 1:0 read 0.
- mcause 0x342 and mtval 0x343: all 32 bits writable.
- mip 0x344: read-only; MEIP bit11 = ext_irq_i and MTIP bit7 = tmr_irq_i, sampled directly, unregistered.
- mcycle 0xB00 / mcycleh 0xB80 and minstret 0xB02 / minstreth 0xB82: read/write.
- cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only aliases of the machine counters.

Reads:
- Purely combinational from current register state. No write bypass: a write becomes visible on rdata_o the cycle after we_i.
- An unimplemented address gives rdata_o = 0 and illegal_o = 1.

Writes:
- Registered on the clock edge when we_i = 1.
- Writes to read-only or unimplemented addresses are silently dropped and change no state.

Counters:
- mcycle (64-bit) increments by 1 every cycle.
- minstret (64-bit) increments by 1 when instret_i = 1.
- The carry from bit 31 propagates into bit 32 in the same cycle.
- 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- A software write to either 32-bit half wins over the increment in that cycle. The written half takes wdata_i, the other half holds its value, and counting resumes on the next cycle.
- With COUNTER_EN = 0, the counters stay 0 and writes to them are dropped.

Trap and mret, same-cycle priority trap_i > mret_i > we_i:
- On trap_i: mepc <= {trap_pc_i[31:2], 2'b00}; mcause <= trap_cause_i; mtval <= trap_val_i; MPIE <= MIE; MIE <= 0.
- On mret_i: MIE <= MPIE; MPIE <= 1.
- A we_i in a cycle with trap_i or mret_i is dropped only if it targets mstatus, mepc, mcause or mtval. Writes to other CSRs still commit.

Interrupt:
- irq_pending_o is registered: it takes MIE & |(mie & mip) using register values at the edge, so it is 1 cycle late relative to the irq inputs.

Outputs: mtvec_o and mepc_o are direct register outputs with the masked low bits (bits 1:0 = 0).

Test Plan:
1. Reset, then rst_ni=1 for 10 cycles: raddr 0xF14 returns HART_ID; 0x301 returns 0x40001100; 0x300 returns 0x00001800; 0x7C0 returns 0 with illegal_o=1.
2. Mask check: write 0xFFFFFFFF to 0x305, 0x341, 0x304 and 0x301. Reads return 0xFFFFFFFC, 0xFFFFFFFC, 0x00000888, and 0x40001100 (write dropped).
3. Counter carry: write mcycle=0xFFFFFFFE and mcycleh=0x5. Reading mcycle/mcycleh gives 0xFFFFFFFF/0x5 one cycle after the mcycle write, then 0x0/0x6 the following cycle. Pulse instret_i 3 times and instret 0xC02 reads 3.
4. Trap: set mstatus=0x8, then trap_i with pc=0x1002, cause=0x8000000B, val=0x55. Next cycle: mepc_o=0x1000, mcause=0x8000000B, mstatus=0x1880. After mret_i: mstatus=0x1888.
5. Interrupt: mie=0x800, mstatus.MIE=1, ext_irq_i rises. irq_pending_o=1 one cycle later and mip reads 0x800; clearing MIE drops irq_pending_o the following cycle.
6. Async reset mid-count: assert rst_ni between edges. All state clears immediately without a clock edge; trap_i together with we_i to mepc in the same cycle leaves mepc at the trap PC.
